// File: rtl/audio_sched.sv
// audio_sched: multi-channel audio sample scheduler in front of the
// sigma-delta DAC.
//
// Each channel has a period counter that marks a sample as pending when it
// expires. A round-robin arbiter fetches pending samples through one memory
// read port with a req/ack handshake. The fetched signed samples are summed,
// scaled down by the channel count and offset to unsigned for the DAC.
//
// Ports:
//   clk, reset_ni        clock, asynchronous active-low reset
//   cfg_wr_i             one-cycle config write strobe for channel cfg_chan_i
//   cfg_en_i             channel enable
//   cfg_period_i         clocks between samples minus 1
//   cfg_base_i           sample buffer start address
//   cfg_len_i            buffer length in bytes (0 = silent)
//   mem_req_o/mem_addr_o fetch request and byte address, held until ack
//   mem_ack_i/mem_data_i fetch done, signed 8-bit sample valid this cycle
//   dac_value_o          registered unsigned offset-binary mix
//   overrun_o            sticky per-channel overrun flags
module audio_sched #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int PERIOD_W = 15,
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 16
) (
  input  logic                        clk,
  input  logic                        reset_ni,
  input  logic                        cfg_wr_i,
  input  logic [$clog2(CHANNELS)-1:0] cfg_chan_i,
  input  logic                        cfg_en_i,
  input  logic [PERIOD_W-1:0]         cfg_period_i,
  input  logic [ADDR_W-1:0]           cfg_base_i,
  input  logic [LEN_W-1:0]            cfg_len_i,
  output logic                        mem_req_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  input  logic                        mem_ack_i,
  input  logic [7:0]                  mem_data_i,
  output logic [WIDTH-1:0]            dac_value_o,
  output logic [CHANNELS-1:0]         overrun_o
);

  localparam int CH_W  = $clog2(CHANNELS);
  localparam int SUM_W = 8 + CH_W;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // Per-channel state
  logic [CHANNELS-1:0] en_q, en_d, pending_q, pending_d, overrun_q, overrun_d;
  logic [PERIOD_W-1:0] period_q [CHANNELS];
  logic [PERIOD_W-1:0] period_d [CHANNELS];
  logic [PERIOD_W-1:0] cnt_q    [CHANNELS];
  logic [PERIOD_W-1:0] cnt_d    [CHANNELS];
  logic [ADDR_W-1:0]   base_q   [CHANNELS];
  logic [ADDR_W-1:0]   base_d   [CHANNELS];
  logic [LEN_W-1:0]    len_q    [CHANNELS];
  logic [LEN_W-1:0]    len_d    [CHANNELS];
  logic [LEN_W-1:0]    pos_q    [CHANNELS];
  logic [LEN_W-1:0]    pos_d    [CHANNELS];
  logic [LEN_W-1:0]    len_new  [CHANNELS];
  logic [LEN_W-1:0]    pos_inc  [CHANNELS];
  logic [7:0]          sample_q [CHANNELS];
  logic [7:0]          sample_d [CHANNELS];
  logic [CHANNELS-1:0] cfg_hit, ack_hit;

  // Arbiter state
  state_t            state_q, state_d;
  logic [CH_W-1:0]   chan_q, last_q, pick_chan, idx;
  logic              pick_valid, ack_fire;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;

  // Mixer
  logic signed [SUM_W-1:0] sum;
  logic [WIDTH-1:0]        mix_d, dac_q;

  // An ack is only meaningful while a request is outstanding.
  assign ack_fire = (state_q == S_REQ) && mem_ack_i;

  // Per-channel next state. Ack is applied first, then the counter (so an
  // expiry in the ack cycle leaves pending set), then config, which wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update;
    // a path that leaves one unassigned would infer a latch.
    for (int c = 0; c < CHANNELS; c++) begin
      cfg_hit[c]   = cfg_wr_i && (cfg_chan_i == CH_W'(c));
      ack_hit[c]   = ack_fire && (chan_q == CH_W'(c));
      len_new[c]   = cfg_hit[c] ? cfg_len_i : len_q[c];
      pos_inc[c]   = pos_q[c] + LEN_W'(1);
      en_d[c]      = en_q[c];
      pending_d[c] = pending_q[c];
      overrun_d[c] = overrun_q[c];
      period_d[c]  = period_q[c];
      cnt_d[c]     = cnt_q[c];
      base_d[c]    = base_q[c];
      len_d[c]     = len_q[c];
      pos_d[c]     = pos_q[c];
      sample_d[c]  = sample_q[c];

      if (ack_hit[c]) begin
        pending_d[c] = 1'b0;
        // Data for a channel that was disabled mid-fetch is dropped.
        if (en_q[c]) begin
          sample_d[c] = mem_data_i;
          pos_d[c]    = (pos_inc[c] >= len_new[c]) ? '0 : pos_inc[c];
        end
      end

      if (en_q[c] && (len_q[c] != '0)) begin
        if (cnt_q[c] == '0) begin
          cnt_d[c]     = period_q[c];
          pending_d[c] = 1'b1;
          if (pending_q[c] && !ack_hit[c]) overrun_d[c] = 1'b1;
        end else begin
          cnt_d[c] = cnt_q[c] - PERIOD_W'(1);
        end
      end

      if (cfg_hit[c]) begin
        en_d[c]      = cfg_en_i;
        period_d[c]  = cfg_period_i;
        base_d[c]    = cfg_base_i;
        len_d[c]     = cfg_len_i;
        overrun_d[c] = 1'b0;
        if (!cfg_en_i) begin
          pending_d[c] = 1'b0;
          sample_d[c]  = '0;
          pos_d[c]     = '0;
        end else if (!en_q[c]) begin
          // Freshly enabled: start timing from the new period right away.
          cnt_d[c] = cfg_period_i;
          pos_d[c] = '0;
        end else if (pos_d[c] >= cfg_len_i) begin
          pos_d[c] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      en_q      <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      // NOTE: the per-channel arrays are reset too; a stale counter or
      // pending bit would launch fetches before the channel is configured.
      for (int c = 0; c < CHANNELS; c++) begin
        period_q[c] <= '0;
        cnt_q[c]    <= '0;
        base_q[c]   <= '0;
        len_q[c]    <= '0;
        pos_q[c]    <= '0;
        sample_q[c] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      en_q      <= en_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      for (int c = 0; c < CHANNELS; c++) begin
        period_q[c] <= period_d[c];
        cnt_q[c]    <= cnt_d[c];
        base_q[c]   <= base_d[c];
        len_q[c]    <= len_d[c];
        pos_q[c]    <= pos_d[c];
        sample_q[c] <= sample_d[c];
      end
    end
  end

  // Round-robin pick: first pending channel at or after last_served+1.
  always_comb begin
    pick_valid = 1'b0;
    pick_chan  = '0;
    idx        = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = last_q + CH_W'(k + 1);
      if (!pick_valid && pending_q[idx]) begin
        pick_valid = 1'b1;
        pick_chan  = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pick_valid) state_d = S_REQ;
      S_REQ:   if (mem_ack_i)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      last_q  <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && pick_valid) begin
        chan_q <= pick_chan;
        addr_q <= base_q[pick_chan] + ADDR_W'(pos_q[pick_chan]);
        req_q  <= 1'b1;
      end else if (ack_fire) begin
        req_q  <= 1'b0;
        last_q <= chan_q;
      end
    end
  end

  // Signed sum, divided by the channel count so it cannot overflow, then
  // offset to unsigned by adding mid-scale.
  always_comb begin
    sum = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      sum = sum + {{CH_W{sample_q[c][7]}}, sample_q[c]};
    end
    mix_d = WIDTH'(sum >>> CH_W) + WIDTH'(1 << (WIDTH - 1));
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) dac_q <= WIDTH'(1 << (WIDTH - 1));
    else           dac_q <= mix_d;
  end

  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign dac_value_o = dac_q;
  assign overrun_o   = overrun_q;

endmodule
